mfe_led7seg_scan_driver: RTL and testbench
==========================================

// Module: mfe_led7seg_scan_driver
// PURPOSE
//  Upstream stage of the 74HC595 LED7SEG controller. Holds a frame of DIG_NUM hex digits plus
//  per-digit DP and blank masks, decodes one digit at a time to segments, and issues one
//  {seg,dig} word per scan tick to the shift controller over vld/rdy. Double-buffered frame
//  input prevents tearing.
// PARAMETERS
//  DIG_NUM      8    number of digits (one-hot digit select width)
//  SCAN_DIV     2000 clk cycles per scan tick (>=4)
//  SEG_ACT_LOW  1    1: segment bits inverted at output (common-anode)
//  DIG_ACT_LOW  0    1: digit select bits inverted at output
//  localparam SEG_NUM = 8 (fixed); DAT_WIDTH = DIG_NUM+SEG_NUM
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous reset, active-high
//  en         in   1            1: scan running; 0: blank display and idle
//  frm_hex    in   4*DIG_NUM    digit i code at [4i+3:4i], values 0..F
//  frm_dp     in   DIG_NUM      bit i lights DP of digit i
//  frm_blank  in   DIG_NUM      bit i forces digit i segments off
//  frm_vld    in   1            load strobe for frm_* into shadow buffer
//  dat        out  DAT_WIDTH    {seg[7:0], dig[DIG_NUM-1:0]} to shift controller
//  vld        out  1            one-cycle word strobe to shift controller
//  rdy        in   1            shift controller idle
//  frm_pend   out  1            shadow loaded, not yet promoted to active frame
// BEHAVIOUR
//  Reset: dat=0, vld=0, frm_pend=0, idx=0, tick counter=0, tick_pend=0, FSM=IDLE; active and
//   shadow frames: hex=0, dp=0, blank=all 1s.
//  Frame: frm_vld captures frm_* into shadow in the same cycle, sets frm_pend (overwrites any
//   prior pending frame). Shadow is copied to active only when a word for idx 0 is built;
//   frm_pend clears in that cycle unless frm_vld is also high (new data wins, stays pending).
//  Tick: counter 0..SCAN_DIV-1 runs only when en=1; tick = count==SCAN_DIV-1. A tick sets
//   tick_pend; tick_pend clears when a word is sent. Ticks during a busy transfer are not lost
//   (at most one held). en=0 clears the counter and tick_pend.
//  Decode (active-high, bit0=a..bit6=g, bit7=dp): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//   8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. blank => seg[6:0]=0 (dp=0 too).
//   dig = one-hot bit idx. Invert seg / dig per SEG_ACT_LOW / DIG_ACT_LOW after decode.
//  FSM:
//   IDLE  : tick_pend & rdy & en -> SEND; en=0 & !blanked -> BLANK
//   SEND  : dat<=word(idx), vld=1 for exactly this cycle; idx<=idx+1, wrap DIG_NUM-1 -> 0;
//           -> GUARD
//   GUARD : one cycle, rdy ignored (controller drops rdy the cycle after vld) -> WAIT
//   WAIT  : rdy=1 -> IDLE
//   BLANK : rdy=1 -> dat<=all segments off, all digits off (polarity applied), vld=1 one
//           cycle, set blanked, idx<=0 -> GUARD
//   blanked clears when en=1 and a SEND occurs.
//  Latency: tick in cycle t with FSM in IDLE and rdy=1 -> vld high in t+2.
//  vld is never asserted while rdy=0 and never in two consecutive cycles. dat holds its value
//   between strobes.
//  en falling mid-transfer: current transfer completes (WAIT), then one BLANK word is sent.
//  en rising: counter restarts at 0; first word is idx 0 after SCAN_DIV cycles.
//  rst mid-transfer: all state reset immediately; vld=0 next cycle regardless of rdy.
// TESTING
//  1 Reset, en=1, frm_hex=0x76543210, blank=0, frm_vld pulse -> 8 words, dig 01..80,
//    seg ~3F,~06,~5B,... (SEG_ACT_LOW=1), spaced SCAN_DIV cycles; idx wraps to 0 after 80.
//  2 frm_vld mid-sweep (idx=3) -> frm_pend=1; idx 3..7 keep old data; idx 0 uses new frame;
//    frm_pend=0 on that word.
//  3 rdy held low 3*SCAN_DIV cycles -> single word on rdy rise (one held tick), no vld while
//    rdy=0.
//  4 frm_blank=0x04, frm_dp=0x01 -> digit 2 seg=FF (all off, active-low), digit 0 seg=~BF.
//  5 en 1->0 during WAIT -> after rdy=1, one word dat=FF00 (SEG low, DIG high polarity), then
//    no vld for 10*SCAN_DIV cycles.
//  6 rst asserted the cycle after vld -> vld=0, frm_pend=0, next word after release is idx 0.

Source files
------------

// File: rtl/mfe_led7seg_scan_driver.sv
// Scan driver for a 74HC595-based 7-segment display.
// Keeps a double-buffered frame of hex digits, decodes one digit per scan tick
// and hands a {seg, dig} word to the shift controller over a vld/rdy handshake.
module mfe_led7seg_scan_driver #(
    parameter int DIG_NUM     = 8,
    parameter int SCAN_DIV    = 2000,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 0,
    localparam int SEG_NUM    = 8,
    localparam int DAT_WIDTH  = DIG_NUM + SEG_NUM
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [4*DIG_NUM-1:0]   frm_hex,
    input  logic [DIG_NUM-1:0]     frm_dp,
    input  logic [DIG_NUM-1:0]     frm_blank,
    input  logic                   frm_vld,
    output logic [DAT_WIDTH-1:0]   dat,
    output logic                   vld,
    input  logic                   rdy,
    output logic                   frm_pend
);

    localparam int IDX_W = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIG_NUM - 1);
    localparam logic [SEG_NUM-1:0] SEG_OFF = (SEG_ACT_LOW != 0) ? '1 : '0;
    localparam logic [DIG_NUM-1:0] DIG_OFF = (DIG_ACT_LOW != 0) ? '1 : '0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEND  = 3'd1;
    localparam logic [2:0] S_GUARD = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_BLANK = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tick_pend_q, tick_pend_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   blanked_q, blanked_d;
    logic [DAT_WIDTH-1:0]   dat_q, dat_d;
    logic                   vld_q, vld_d;
    logic                   frm_pend_q, frm_pend_d;
    logic [4*DIG_NUM-1:0]   act_hex_q, act_hex_d, shd_hex_q, shd_hex_d;
    logic [DIG_NUM-1:0]     act_dp_q, act_dp_d, shd_dp_q, shd_dp_d;
    logic [DIG_NUM-1:0]     act_blank_q, act_blank_d, shd_blank_q, shd_blank_d;

    logic                   tick;
    logic                   use_shadow;
    logic [4*DIG_NUM-1:0]   sel_hex;
    logic [DIG_NUM-1:0]     sel_dp, sel_blank;
    logic [3:0]             hex_nib [DIG_NUM];
    logic [3:0]             cur_nib;
    logic [DIG_NUM-1:0]     dig_raw;
    logic [6:0]             seg7;
    logic [SEG_NUM-1:0]     seg_raw;
    logic [DAT_WIDTH-1:0]   scan_word;

    // The word for digit 0 is the promotion point, so it is built straight from the shadow.
    assign use_shadow = frm_pend_q && (idx_q == '0);
    assign sel_hex    = use_shadow ? shd_hex_q   : act_hex_q;
    assign sel_dp     = use_shadow ? shd_dp_q    : act_dp_q;
    assign sel_blank  = use_shadow ? shd_blank_q : act_blank_q;
    assign cur_nib    = hex_nib[idx_q];
    assign tick       = en && (cnt_q == CNT_MAX);

    generate
        for (genvar gi = 0; gi < DIG_NUM; gi++) begin : g_digit
            assign hex_nib[gi] = sel_hex[4*gi +: 4];
            assign dig_raw[gi] = (idx_q == IDX_W'(gi));
        end
    endgenerate

    // Decode the selected digit to segments and apply output polarities.
    always_comb begin
        seg7 = 7'h00;
        case (cur_nib)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
        seg_raw   = sel_blank[idx_q] ? '0 : {sel_dp[idx_q], seg7};
        scan_word = {(SEG_ACT_LOW != 0) ? ~seg_raw : seg_raw,
                     (DIG_ACT_LOW != 0) ? ~dig_raw : dig_raw};
    end

    // Next-state logic: tick counter, held tick, frame buffers and the handshake FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        blanked_d   = blanked_q;
        dat_d       = dat_q;
        vld_d       = 1'b0;
        frm_pend_d  = frm_pend_q;
        act_hex_d   = act_hex_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        shd_hex_d   = shd_hex_q;
        shd_dp_d    = shd_dp_q;
        shd_blank_d = shd_blank_q;

        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A tick in the SEND cycle survives; otherwise SEND consumes the held tick.
        if (!en) begin
            tick_pend_d = 1'b0;
        end else if (tick) begin
            tick_pend_d = 1'b1;
        end else if (state_q == S_SEND) begin
            tick_pend_d = 1'b0;
        end else begin
            tick_pend_d = tick_pend_q;
        end

        case (state_q)
            S_IDLE: begin
                if ((tick_pend_q || tick) && rdy && en) begin
                    state_d = S_SEND;
                end else if (!en && !blanked_q) begin
                    state_d = S_BLANK;
                end
            end
            S_SEND: begin
                dat_d   = scan_word;
                vld_d   = 1'b1;
                idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
                state_d = S_GUARD;
                if (en) begin
                    blanked_d = 1'b0;
                end
                if (use_shadow) begin
                    act_hex_d   = shd_hex_q;
                    act_dp_d    = shd_dp_q;
                    act_blank_d = shd_blank_q;
                    frm_pend_d  = 1'b0;
                end
            end
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                if (rdy) begin
                    state_d = S_IDLE;
                end
            end
            S_BLANK: begin
                if (rdy) begin
                    dat_d     = {SEG_OFF, DIG_OFF};
                    vld_d     = 1'b1;
                    blanked_d = 1'b1;
                    idx_d     = '0;
                    state_d   = S_GUARD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh frame always wins over a promotion in the same cycle.
        if (frm_vld) begin
            shd_hex_d   = frm_hex;
            shd_dp_d    = frm_dp;
            shd_blank_d = frm_blank;
            frm_pend_d  = 1'b1;
        end
    end

    // State registers with synchronous reset; frames reset to fully blanked.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tick_pend_q <= 1'b0;
            idx_q       <= '0;
            blanked_q   <= 1'b0;
            dat_q       <= '0;
            vld_q       <= 1'b0;
            frm_pend_q  <= 1'b0;
            act_hex_q   <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '1;
            shd_hex_q   <= '0;
            shd_dp_q    <= '0;
            shd_blank_q <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tick_pend_q <= tick_pend_d;
            idx_q       <= idx_d;
            blanked_q   <= blanked_d;
            dat_q       <= dat_d;
            vld_q       <= vld_d;
            frm_pend_q  <= frm_pend_d;
            act_hex_q   <= act_hex_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            shd_hex_q   <= shd_hex_d;
            shd_dp_q    <= shd_dp_d;
            shd_blank_q <= shd_blank_d;
        end
    end

    assign dat      = dat_q;
    assign vld      = vld_q;
    assign frm_pend = frm_pend_q;

endmodule

// File: tb/tb_mfe_led7seg_scan_driver.sv
// Bench for the 7-segment scan driver: table vectors, directed corner sequences
// and randomized traffic checked against a frame/digit reference model.
module tb_mfe_led7seg_scan_driver;

    localparam int DIG_NUM     = 8;
    localparam int SCAN_DIV    = 16;
    localparam int SEG_ACT_LOW = 1;
    localparam int DIG_ACT_LOW = 0;
    localparam int DW          = DIG_NUM + 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b1;
    logic [4*DIG_NUM-1:0] frm_hex = '0;
    logic [DIG_NUM-1:0] frm_dp = '0;
    logic [DIG_NUM-1:0] frm_blank = '0;
    logic              frm_vld = 1'b0;
    logic [DW-1:0]     dat;
    logic              vld;
    logic              rdy;
    logic              frm_pend;

    mfe_led7seg_scan_driver #(
        .DIG_NUM(DIG_NUM), .SCAN_DIV(SCAN_DIV),
        .SEG_ACT_LOW(SEG_ACT_LOW), .DIG_ACT_LOW(DIG_ACT_LOW)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .frm_hex(frm_hex), .frm_dp(frm_dp), .frm_blank(frm_blank), .frm_vld(frm_vld),
        .dat(dat), .vld(vld), .rdy(rdy), .frm_pend(frm_pend)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [DW-1:0] dat;
        int            cyc;
        logic          rdy_ok;
        logic          b2b;
    } word_t;

    typedef struct {
        logic [3:0] hex;
        logic       dp;
        logic       blank;
        logic [7:0] exp_seg;
    } vec_t;

    word_t words[$];
    int    busy_len = 2;
    bit    hold_low = 1'b0;
    int    hold_viol = 0;
    int    mon_busy = 0;
    logic  mon_prev_vld = 1'b0;
    logic [DW-1:0] mon_last_dat = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int base    = 0;

    // Reference model state: active frame, pending frame, next digit index.
    logic [6:0]  seg7_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [31:0] m_hex, m_p_hex;
    logic [7:0]  m_dp, m_blank, m_p_dp, m_p_blank;
    bit          m_pend;
    int          m_idx;

    // Shift-controller stand-in and word monitor: drops rdy for busy_len cycles after each strobe.
    initial begin
        rdy = 1'b1;
        forever begin
            word_t w;
            @(negedge clk);
            if (vld === 1'b1) begin
                w.dat = dat;
                w.cyc = cyc_cnt;
                w.rdy_ok = rdy;
                w.b2b = mon_prev_vld;
                words.push_back(w);
                mon_busy = busy_len;
            end else if (mon_busy > 0) begin
                mon_busy--;
            end
            if (rst || vld === 1'b1) begin
                mon_last_dat = dat;
            end else if (dat !== mon_last_dat) begin
                hold_viol++;
                mon_last_dat = dat;
            end
            mon_prev_vld = (vld === 1'b1);
            rdy = !(mon_busy > 0 || hold_low);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_hex = '0; m_dp = '0; m_blank = '1;
        m_pend = 1'b0; m_idx = 0;
    endfunction

    function automatic logic [DW-1:0] model_next();
        logic [7:0] seg;
        logic [7:0] dig;
        if (m_idx == 0 && m_pend) begin
            m_hex = m_p_hex; m_dp = m_p_dp; m_blank = m_p_blank;
            m_pend = 1'b0;
        end
        if (m_blank[m_idx]) seg = 8'h00;
        else seg = {m_dp[m_idx], seg7_tbl[m_hex[4*m_idx +: 4]]};
        if (SEG_ACT_LOW != 0) seg = ~seg;
        dig = 8'(1 << m_idx);
        if (DIG_ACT_LOW != 0) dig = ~dig;
        m_idx = (m_idx + 1) % DIG_NUM;
        return {seg, dig};
    endfunction

    task automatic load_frame(input logic [31:0] h, input logic [7:0] d, input logic [7:0] b);
        frm_hex = h; frm_dp = d; frm_blank = b; frm_vld = 1'b1;
        @(negedge clk);
        frm_vld = 1'b0;
        m_p_hex = h; m_p_dp = d; m_p_blank = b; m_pend = 1'b1;
        check("frm_pend set", 32'(frm_pend), 32'd1);
        #1;
    endtask

    task automatic get_word(input int limit, output word_t w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (words.size() > 0) break;
            @(negedge clk);
            #1;
        end
        if (words.size() > 0) begin
            w = words.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic expect_next(input string name, input bit phase_chk);
        word_t w;
        bit ok;
        logic [DW-1:0] e;
        get_word(2 * SCAN_DIV + 16, w, ok);
        check({name, " arrive"}, 32'(ok), 32'd1);
        if (ok) begin
            e = model_next();
            check({name, " dat"}, 32'(w.dat), 32'(e));
            check({name, " rdy at vld"}, 32'(w.rdy_ok), 32'd1);
            check({name, " vld b2b"}, 32'(w.b2b), 32'd0);
            if (phase_chk) check({name, " phase"}, 32'((w.cyc - base) % SCAN_DIV), 32'd1);
        end
    endtask

    initial begin
        vec_t tbl [16];
        word_t w;
        bit ok;
        logic [31:0] fh;
        logic [7:0] fd, fb;

        tbl[0]  = '{4'h0, 1'b1, 1'b0, 8'h40};
        tbl[1]  = '{4'h1, 1'b0, 1'b0, 8'hF9};
        tbl[2]  = '{4'h2, 1'b0, 1'b1, 8'hFF};
        tbl[3]  = '{4'h3, 1'b0, 1'b0, 8'hB0};
        tbl[4]  = '{4'h4, 1'b1, 1'b0, 8'h19};
        tbl[5]  = '{4'h5, 1'b0, 1'b0, 8'h92};
        tbl[6]  = '{4'h6, 1'b0, 1'b0, 8'h82};
        tbl[7]  = '{4'h7, 1'b1, 1'b1, 8'hFF};
        tbl[8]  = '{4'h8, 1'b0, 1'b0, 8'h80};
        tbl[9]  = '{4'h9, 1'b1, 1'b0, 8'h10};
        tbl[10] = '{4'hA, 1'b0, 1'b0, 8'h88};
        tbl[11] = '{4'hB, 1'b0, 1'b0, 8'h83};
        tbl[12] = '{4'hC, 1'b1, 1'b0, 8'h46};
        tbl[13] = '{4'hD, 1'b0, 1'b0, 8'hA1};
        tbl[14] = '{4'hE, 1'b0, 1'b0, 8'h86};
        tbl[15] = '{4'hF, 1'b0, 1'b0, 8'h8E};

        // Reset state.
        rst = 1'b1; en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst dat", 32'(dat), 32'd0);
        check("rst vld", 32'(vld), 32'd0);
        check("rst frm_pend", 32'(frm_pend), 32'd0);
        rst = 1'b0;
        base = cyc_cnt;
        model_reset();
        @(negedge clk);

        // Full sweep of a 0..7 frame, spaced one tick apart.
        load_frame(32'h76543210, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) expect_next($sformatf("sweep d%0d", i), 1'b1);

        // New frame mid-sweep stays pending until digit 0 is rebuilt.
        for (int i = 0; i < 3; i++) expect_next($sformatf("pre d%0d", i), 1'b1);
        load_frame(32'hFEDCBA98, 8'h0F, 8'h00);
        for (int i = 3; i < 8; i++) expect_next($sformatf("old d%0d", i), 1'b1);
        check("pend before d0", 32'(frm_pend), 32'd1);
        expect_next("promote d0", 1'b1);
        check("pend after d0", 32'(frm_pend), 32'd0);

        // rdy held low across three ticks: one held word on release, then back on phase.
        hold_low = 1'b1;
        repeat (3 * SCAN_DIV) @(negedge clk);
        #1;
        check("no vld while rdy low", 32'(words.size()), 32'd0);
        hold_low = 1'b0;
        expect_next("held word", 1'b0);
        expect_next("after held 1", 1'b1);
        expect_next("after held 2", 1'b1);

        // Decode table: two frames covering all codes with dp and blank mixes.
        for (int f = 0; f < 2; f++) begin
            fh = '0; fd = '0; fb = '0;
            for (int i = 0; i < 8; i++) begin
                fh[4*i +: 4] = tbl[f*8+i].hex;
                fd[i] = tbl[f*8+i].dp;
                fb[i] = tbl[f*8+i].blank;
            end
            load_frame(fh, fd, fb);
            while (m_idx != 0) expect_next("align", 1'b1);
            for (int i = 0; i < 8; i++) begin
                get_word(2 * SCAN_DIV + 16, w, ok);
                check($sformatf("tbl f%0d d%0d arrive", f, i), 32'(ok), 32'd1);
                if (ok) begin
                    check($sformatf("tbl f%0d d%0d dat", f, i), 32'(w.dat),
                          32'({tbl[f*8+i].exp_seg, 8'(1 << i)}));
                    void'(model_next());
                end
            end
        end

        // en falls during the transfer: one blank word, then silence.
        en = 1'b0;
        get_word(2 * SCAN_DIV, w, ok);
        check("blank arrive", 32'(ok), 32'd1);
        if (ok) begin
            check("blank dat", 32'(w.dat), 32'h0000FF00);
            check("blank rdy at vld", 32'(w.rdy_ok), 32'd1);
        end
        m_idx = 0;
        repeat (10 * SCAN_DIV) @(negedge clk);
        #1;
        check("idle while disabled", 32'(words.size()), 32'd0);
        en = 1'b1;
        base = cyc_cnt;
        expect_next("resume d0", 1'b1);

        // Reset right after a strobe with a frame pending.
        load_frame(32'h13579BDF, 8'hAA, 8'h00);
        expect_next("pre-rst d1", 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst vld", 32'(vld), 32'd0);
        check("mid rst frm_pend", 32'(frm_pend), 32'd0);
        check("mid rst dat", 32'(dat), 32'd0);
        rst = 1'b0;
        base = cyc_cnt;
        model_reset();
        get_word(2 * SCAN_DIV + 16, w, ok);
        check("post rst arrive", 32'(ok), 32'd1);
        if (ok) begin
            check("post rst idx0 blank", 32'(w.dat), 32'h0000FF01);
            check("post rst phase", 32'((w.cyc - base) % SCAN_DIV), 32'd1);
            void'(model_next());
        end

        // Randomized traffic: random controller busy time and random frame loads.
        load_frame($urandom, 8'($urandom), 8'($urandom));
        for (int k = 0; k < 48; k++) begin
            busy_len = $urandom_range(1, SCAN_DIV - 4);
            expect_next($sformatf("rnd %0d", k), 1'b1);
            if ($urandom_range(0, 3) == 0) load_frame($urandom, 8'($urandom), 8'($urandom));
        end

        check("dat held between strobes", 32'(hold_viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
